// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
// Shared CPU types used by the pipeline control logic.
//   regbits_t       : 5-bit architectural register index
//   hazard_state_t  : hazard unit FSM state {RUN, DSTALL, HALTED}
//   pipe_ctrl_t     : bundle of pipeline register enables / flushes
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DSTALL = 2'd1,
      HALTED = 2'd2
   } hazard_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic ifid_flush;
      logic idex_en;
      logic idex_flush;
      logic exmem_en;
      logic memwb_en;
   } pipe_ctrl_t;

   // Every stage advances, nothing is squashed.
   localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   // Whole pipeline holds its contents.
   localparam pipe_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
   // Fetch/decode hold, a bubble enters EX, the back end drains.
   localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
   // Wrong-path instructions in IF/ID and ID/EX are squashed.
   localparam pipe_ctrl_t CTRL_BRANCH = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// ----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with synchronous clear.
//   clk   : clock, rising edge
//   clear : synchronous clear (wins over inc)
//   inc   : count up by one this cycle, sticking at all-ones
//   count : current value
// ----------------------------------------------------------------------------
module sat_counter #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             clear,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   // NOTE: sequential state is written with <= so every flop samples the
   // pre-edge values of its inputs regardless of block evaluation order.
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// hazard_unit
// Pipeline hazard/stall controller for a 5-stage core.
// Inputs:
//   CLK, nRST            : clock and synchronous active-low reset
//   ihit, dhit           : instruction / data memory handshakes
//   dREN_MEM, dWEN_MEM   : MEM-stage data request
//   rs_ID, rt_ID         : decode-stage source registers, uses_rt_ID
//   memtoReg_EX, datomic_EX, RegWr_EX, final_wsel_EX : EX-stage producer info
//   branch_taken_EX      : taken branch/jump resolved in EX
//   halt_MEM             : halt instruction in MEM
// Outputs:
//   pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en
//   halted               : core stopped until reset
//   stall_cnt, flush_cnt : saturating performance counters
// Controls are combinational from state and inputs (zero-cycle latency).
// ----------------------------------------------------------------------------
module hazard_unit
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             dREN_MEM,
   input  logic             dWEN_MEM,
   input  regbits_t         rs_ID,
   input  regbits_t         rt_ID,
   input  logic             uses_rt_ID,
   input  logic             memtoReg_EX,
   input  logic             datomic_EX,
   input  logic             RegWr_EX,
   input  regbits_t         final_wsel_EX,
   input  logic             branch_taken_EX,
   input  logic             halt_MEM,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hazard_state_t state_q, state_d, state_eff;
   pipe_ctrl_t    ctrl;
   logic          dstall, loaduse;

   assign dstall = (dREN_MEM | dWEN_MEM) & ~dhit;

   // An atomic that writes back behaves like a load: its result is only
   // available after MEM. Writes to $0 never create a dependency.
   assign loaduse = (memtoReg_EX | (datomic_EX & RegWr_EX))
                  & (final_wsel_EX != '0)
                  & ((final_wsel_EX == rs_ID) | (uses_rt_ID & (final_wsel_EX == rt_ID)));

   // While reset is asserted the controls decode as RUN, so a reset taken
   // mid-DSTALL or in HALTED never shows a frozen pipeline.
   assign state_eff = nRST ? state_q : RUN;

   // NOTE: every signal written here gets a default first, so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      ctrl    = CTRL_RUN;
      state_d = state_eff;
      case (state_eff)
         HALTED: begin
            ctrl = CTRL_FREEZE;
         end
         default: begin
            if (dstall) begin
               ctrl    = CTRL_FREEZE;
               state_d = DSTALL;
            end else if (halt_MEM) begin
               ctrl    = CTRL_FREEZE;
               state_d = HALTED;
            end else begin
               state_d = RUN;
               // A branch held in EX through a DSTALL lands here on the
               // first unstalled cycle; ID/EX was frozen, so nothing is lost.
               if (branch_taken_EX) begin
                  ctrl = CTRL_BRANCH;
               end else if (loaduse || !ihit) begin
                  ctrl = CTRL_BUBBLE;
               end
            end
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!nRST) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   assign pc_en      = ctrl.pc_en;
   assign ifid_en    = ctrl.ifid_en;
   assign ifid_flush = ctrl.ifid_flush;
   assign idex_en    = ctrl.idex_en;
   assign idex_flush = ctrl.idex_flush;
   assign exmem_en   = ctrl.exmem_en;
   assign memwb_en   = ctrl.memwb_en;
   assign halted     = (state_eff == HALTED);

   // NOTE: the counters are cleared through their synchronous clear input,
   // driven from nRST, rather than a separate reset path.
   sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
      .clk   (CLK),
      .clear (~nRST),
      .inc   (~ctrl.pc_en & (state_eff != HALTED)),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
      .clk   (CLK),
      .clear (~nRST),
      .inc   (ctrl.idex_flush),
      .count (flush_cnt)
   );

endmodule
